// File: rtl/oflow_dma_pkg.sv
// Shared constants and state encoding for the DMA set feeder.
package oflow_dma_pkg;

    localparam int unsigned DMA_PE_NUM   = 24;
    localparam int unsigned DMA_BBOX_W   = 9;
    localparam int unsigned DMA_ADDR_W   = 12;
    localparam int unsigned DMA_FRAME_W  = 8;
    localparam int unsigned DMA_IDX_W    = 5;
    localparam int unsigned DMA_CREDIT_W = 2;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_WAIT_DESC   = 3'd1,
        S_LAUNCH      = 3'd2,
        S_WAIT_CREDIT = 3'd3,
        S_FETCH       = 3'd4,
        S_DRAIN       = 3'd5,
        S_ANNOUNCE    = 3'd6,
        S_WAIT_FRAME  = 3'd7
    } dma_state_e;

endpackage

// File: rtl/oflow_dma_set_fetch.sv
// Streams one set: one read per cycle from a start address, with the
// buffer write strobe and slot index trailing the read by one cycle.
module oflow_dma_set_fetch
    import oflow_dma_pkg::*;
#(
    parameter int unsigned BBOX_W = DMA_BBOX_W,
    parameter int unsigned ADDR_W = DMA_ADDR_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    start_addr,
    input  logic [BBOX_W-1:0]    start_size,
    output logic                 rd_en,
    output logic [ADDR_W-1:0]    rd_addr,
    output logic                 fe_wr_en,
    output logic [DMA_IDX_W-1:0] fe_wr_idx,
    output logic                 busy,
    output logic                 done
);

    logic                 rd_en_q,     rd_en_d;
    logic [ADDR_W-1:0]    rd_addr_q,   rd_addr_d;
    logic [DMA_IDX_W-1:0] rd_idx_q,    rd_idx_d;
    logic [BBOX_W-1:0]    remain_q,    remain_d;
    logic                 fe_wr_en_q,  fe_wr_en_d;
    logic [DMA_IDX_W-1:0] fe_wr_idx_q, fe_wr_idx_d;

    // Read sequencing: remain_q counts reads still to issue after the current one.
    always_comb begin
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        rd_idx_d    = rd_idx_q;
        remain_d    = remain_q;
        fe_wr_en_d  = rd_en_q;
        fe_wr_idx_d = rd_idx_q;
        if (start) begin
            rd_en_d   = 1'b1;
            rd_addr_d = start_addr;
            rd_idx_d  = '0;
            remain_d  = start_size - BBOX_W'(1);
        end else if (rd_en_q && (remain_q != '0)) begin
            rd_en_d   = 1'b1;
            rd_addr_d = rd_addr_q + ADDR_W'(1);
            rd_idx_d  = rd_idx_q + DMA_IDX_W'(1);
            remain_d  = remain_q - BBOX_W'(1);
        end
    end

    // State registers; reset abandons any set in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            rd_idx_q    <= '0;
            remain_q    <= '0;
            fe_wr_en_q  <= 1'b0;
            fe_wr_idx_q <= '0;
        end else begin
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            rd_idx_q    <= rd_idx_d;
            remain_q    <= remain_d;
            fe_wr_en_q  <= fe_wr_en_d;
            fe_wr_idx_q <= fe_wr_idx_d;
        end
    end

    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign fe_wr_en  = fe_wr_en_q;
    assign fe_wr_idx = fe_wr_idx_q;
    assign busy      = rd_en_q;
    assign done      = rd_en_q && (remain_q == '0);

endmodule

// File: rtl/oflow_dma_set_feeder.sv
// Frame/set feeder for the core FSM: takes a descriptor per frame, launches
// the core, and fetches each set of up to PE_NUM bboxes per granted credit.
module oflow_dma_set_feeder
    import oflow_dma_pkg::*;
#(
    parameter int unsigned PE_NUM  = DMA_PE_NUM,
    parameter int unsigned BBOX_W  = DMA_BBOX_W,
    parameter int unsigned ADDR_W  = DMA_ADDR_W,
    parameter int unsigned FRAME_W = DMA_FRAME_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [FRAME_W-1:0]   num_of_total_frames,
    input  logic                 desc_valid,
    output logic                 desc_ready,
    input  logic [BBOX_W-1:0]    desc_bbox_num,
    input  logic [ADDR_W-1:0]    desc_base_addr,
    output logic                 core_start,
    output logic                 new_frame,
    output logic [BBOX_W-1:0]    num_of_bbox_in_frame,
    input  logic                 ready_new_set,
    input  logic                 ready_new_frame,
    output logic                 new_set_from_dma,
    output logic [BBOX_W-1:0]    set_bbox_count,
    output logic                 rd_en,
    output logic [ADDR_W-1:0]    rd_addr,
    output logic                 fe_wr_en,
    output logic [DMA_IDX_W-1:0] fe_wr_idx,
    output logic [FRAME_W-1:0]   frame_num,
    output logic                 done_all,
    output logic                 credit_err
);

    localparam logic [BBOX_W-1:0]       PE_B       = BBOX_W'(PE_NUM);
    localparam logic [DMA_CREDIT_W-1:0] CREDIT_MAX = '1;

    dma_state_e                state_q, state_d;
    logic [FRAME_W-1:0]        total_q, total_d;
    logic [FRAME_W-1:0]        frame_num_q, frame_num_d;
    logic [BBOX_W-1:0]         bbox_num_q, bbox_num_d;
    logic [BBOX_W-1:0]         bbox_idx_q, bbox_idx_d;
    logic [BBOX_W-1:0]         sets_left_q, sets_left_d;
    logic [BBOX_W-1:0]         set_size_q, set_size_d;
    logic [BBOX_W-1:0]         set_bbox_count_q, set_bbox_count_d;
    logic [ADDR_W-1:0]         base_q, base_d;
    logic [DMA_CREDIT_W-1:0]   credit_q, credit_d;
    logic                      credit_err_q, credit_err_d;
    logic                      frame_flag_q, frame_flag_d;
    logic                      core_start_q, core_start_d;
    logic                      new_frame_q, new_frame_d;
    logic                      new_set_q, new_set_d;
    logic                      done_all_q, done_all_d;

    logic [BBOX_W-1:0]         remain_c;
    logic [BBOX_W-1:0]         set_size_c;
    logic [BBOX_W-1:0]         sets_c;
    logic                      rem_nz_c;
    logic [ADDR_W-1:0]         fetch_addr_c;
    logic                      consume_c;
    logic                      fetch_start_c;
    logic                      fetch_busy_c;
    logic                      fetch_done_c;

    // Per-set and per-frame arithmetic: set size clamp, set count, fetch address.
    always_comb begin
        remain_c     = bbox_num_q - bbox_idx_q;
        set_size_c   = (remain_c > PE_B) ? PE_B : remain_c;
        rem_nz_c     = (desc_bbox_num % PE_B) != '0;
        sets_c       = (desc_bbox_num / PE_B) + BBOX_W'(rem_nz_c);
        fetch_addr_c = base_q + ADDR_W'(bbox_idx_q);
        consume_c    = (state_q == S_WAIT_CREDIT) && (credit_q != '0);
    end

    // Next-state, credit accounting and registered output pulses.
    always_comb begin
        state_d          = state_q;
        total_d          = total_q;
        frame_num_d      = frame_num_q;
        bbox_num_d       = bbox_num_q;
        bbox_idx_d       = bbox_idx_q;
        sets_left_d      = sets_left_q;
        set_size_d       = set_size_q;
        set_bbox_count_d = set_bbox_count_q;
        base_d           = base_q;
        credit_d         = credit_q;
        credit_err_d     = credit_err_q;
        frame_flag_d     = frame_flag_q | ready_new_frame;
        core_start_d     = 1'b0;
        new_frame_d      = 1'b0;
        new_set_d        = 1'b0;
        done_all_d       = 1'b0;
        fetch_start_c    = 1'b0;

        // Simultaneous grant and consumption cancel out; a grant at the
        // saturated count is lost and flagged.
        if (ready_new_set && !consume_c) begin
            if (credit_q == CREDIT_MAX) begin
                credit_err_d = 1'b1;
            end else begin
                credit_d = credit_q + DMA_CREDIT_W'(1);
            end
        end else if (!ready_new_set && consume_c) begin
            credit_d = credit_q - DMA_CREDIT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_of_total_frames != '0) begin
                        total_d      = num_of_total_frames;
                        frame_num_d  = '0;
                        credit_d     = '0;
                        frame_flag_d = 1'b0;
                        state_d      = S_WAIT_DESC;
                    end else begin
                        done_all_d = 1'b1;
                    end
                end
            end
            S_WAIT_DESC: begin
                if (desc_valid) begin
                    bbox_num_d   = desc_bbox_num;
                    base_d       = desc_base_addr;
                    sets_left_d  = sets_c;
                    bbox_idx_d   = '0;
                    core_start_d = (frame_num_q == '0);
                    new_frame_d  = (frame_num_q != '0);
                    state_d      = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_d = (sets_left_q == '0) ? S_WAIT_FRAME : S_WAIT_CREDIT;
            end
            S_WAIT_CREDIT: begin
                if (consume_c) begin
                    set_size_d    = set_size_c;
                    bbox_idx_d    = bbox_idx_q + set_size_c;
                    fetch_start_c = 1'b1;
                    state_d       = S_FETCH;
                end
            end
            S_FETCH: begin
                if (fetch_done_c) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!fetch_busy_c) begin
                    new_set_d        = 1'b1;
                    set_bbox_count_d = set_size_q;
                    state_d          = S_ANNOUNCE;
                end
            end
            S_ANNOUNCE: begin
                sets_left_d = sets_left_q - BBOX_W'(1);
                state_d     = (sets_left_q > BBOX_W'(1)) ? S_WAIT_CREDIT : S_WAIT_FRAME;
            end
            S_WAIT_FRAME: begin
                if (frame_flag_q) begin
                    frame_flag_d = ready_new_frame;
                    frame_num_d  = frame_num_q + FRAME_W'(1);
                    if ((frame_num_q + FRAME_W'(1)) == total_q) begin
                        done_all_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        state_d = S_WAIT_DESC;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            total_q          <= '0;
            frame_num_q      <= '0;
            bbox_num_q       <= '0;
            bbox_idx_q       <= '0;
            sets_left_q      <= '0;
            set_size_q       <= '0;
            set_bbox_count_q <= '0;
            base_q           <= '0;
            credit_q         <= '0;
            credit_err_q     <= 1'b0;
            frame_flag_q     <= 1'b0;
            core_start_q     <= 1'b0;
            new_frame_q      <= 1'b0;
            new_set_q        <= 1'b0;
            done_all_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            total_q          <= total_d;
            frame_num_q      <= frame_num_d;
            bbox_num_q       <= bbox_num_d;
            bbox_idx_q       <= bbox_idx_d;
            sets_left_q      <= sets_left_d;
            set_size_q       <= set_size_d;
            set_bbox_count_q <= set_bbox_count_d;
            base_q           <= base_d;
            credit_q         <= credit_d;
            credit_err_q     <= credit_err_d;
            frame_flag_q     <= frame_flag_d;
            core_start_q     <= core_start_d;
            new_frame_q      <= new_frame_d;
            new_set_q        <= new_set_d;
            done_all_q       <= done_all_d;
        end
    end

    oflow_dma_set_fetch #(
        .BBOX_W (BBOX_W),
        .ADDR_W (ADDR_W)
    ) u_fetch (
        .clk        (clk),
        .reset      (reset),
        .start      (fetch_start_c),
        .start_addr (fetch_addr_c),
        .start_size (set_size_c),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .fe_wr_en   (fe_wr_en),
        .fe_wr_idx  (fe_wr_idx),
        .busy       (fetch_busy_c),
        .done       (fetch_done_c)
    );

    assign desc_ready           = (state_q == S_WAIT_DESC);
    assign core_start           = core_start_q;
    assign new_frame            = new_frame_q;
    assign num_of_bbox_in_frame = bbox_num_q;
    assign new_set_from_dma     = new_set_q;
    assign set_bbox_count       = set_bbox_count_q;
    assign frame_num            = frame_num_q;
    assign done_all             = done_all_q;
    assign credit_err           = credit_err_q;

endmodule

// File: tb/tb_oflow_dma_set_feeder.sv
// Self-checking bench for oflow_dma_set_feeder against a frame/set reference model.
module tb_oflow_dma_set_feeder;

    localparam int unsigned PE = 24;
    localparam int unsigned BW = 9;
    localparam int unsigned AW = 12;
    localparam int unsigned FW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [FW-1:0] num_of_total_frames = '0;
    logic          desc_valid = 1'b0;
    logic          desc_ready;
    logic [BW-1:0] desc_bbox_num = '0;
    logic [AW-1:0] desc_base_addr = '0;
    logic          core_start, new_frame;
    logic [BW-1:0] num_of_bbox_in_frame;
    logic          ready_new_set = 1'b0;
    logic          ready_new_frame = 1'b0;
    logic          new_set_from_dma;
    logic [BW-1:0] set_bbox_count;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          fe_wr_en;
    logic [4:0]    fe_wr_idx;
    logic [FW-1:0] frame_num;
    logic          done_all, credit_err;
    logic [50:0]   out_vec;

    always #5 clk = ~clk;

    oflow_dma_set_feeder dut (
        .clk(clk), .reset(reset), .start(start),
        .num_of_total_frames(num_of_total_frames),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_bbox_num(desc_bbox_num), .desc_base_addr(desc_base_addr),
        .core_start(core_start), .new_frame(new_frame),
        .num_of_bbox_in_frame(num_of_bbox_in_frame),
        .ready_new_set(ready_new_set), .ready_new_frame(ready_new_frame),
        .new_set_from_dma(new_set_from_dma), .set_bbox_count(set_bbox_count),
        .rd_en(rd_en), .rd_addr(rd_addr), .fe_wr_en(fe_wr_en), .fe_wr_idx(fe_wr_idx),
        .frame_num(frame_num), .done_all(done_all), .credit_err(credit_err)
    );

    assign out_vec = {desc_ready, core_start, new_frame, num_of_bbox_in_frame,
                      new_set_from_dma, set_bbox_count, rd_en, rd_addr, fe_wr_en,
                      fe_wr_idx, frame_num, done_all, credit_err};

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed events, recorded mid-cycle.
    logic [AW-1:0] rd_q[$];
    int            rd_cyc_q[$];
    int            wr_q[$];
    int            wr_cyc_q[$];
    int            ln_kind_q[$], ln_frame_q[$], ln_bbox_q[$], ln_cyc_q[$];
    int            set_q[$], set_cyc_q[$];
    int            done_cnt, done_cyc;

    always @(negedge clk) begin
        if (rd_en) begin rd_q.push_back(rd_addr); rd_cyc_q.push_back(cyc); end
        if (fe_wr_en) begin wr_q.push_back(int'(fe_wr_idx)); wr_cyc_q.push_back(cyc); end
        if (core_start || new_frame) begin
            ln_kind_q.push_back((core_start && new_frame) ? 2 : (core_start ? 0 : 1));
            ln_frame_q.push_back(int'(frame_num));
            ln_bbox_q.push_back(int'(num_of_bbox_in_frame));
            ln_cyc_q.push_back(cyc);
        end
        if (new_set_from_dma) begin set_q.push_back(int'(set_bbox_count)); set_cyc_q.push_back(cyc); end
        if (done_all) begin done_cnt++; done_cyc = cyc; end
    end

    // Job description and reference model outputs.
    int            job_bbox[4];
    int            job_base[4];
    logic [AW-1:0] exp_rd_q[$];
    int            exp_idx_q[$];
    int            exp_set_q[$];
    int            cr_cyc_q[$];
    int            start_cyc, rnf_cyc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        rd_q.delete(); rd_cyc_q.delete(); wr_q.delete(); wr_cyc_q.delete();
        ln_kind_q.delete(); ln_frame_q.delete(); ln_bbox_q.delete(); ln_cyc_q.delete();
        set_q.delete(); set_cyc_q.delete(); cr_cyc_q.delete();
        done_cnt = 0; done_cyc = -1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; tick(); tick(); reset = 1'b0; tick();
    endtask

    // Reference model: every bbox read once at base+i (mod 2^AW), written to
    // slot i mod PE, frames split into sets of at most PE.
    function automatic void build_exp(input int nfr);
        int rem;
        exp_rd_q.delete(); exp_idx_q.delete(); exp_set_q.delete();
        for (int f = 0; f < nfr; f++) begin
            for (int i = 0; i < job_bbox[f]; i++) begin
                exp_rd_q.push_back(AW'(job_base[f] + i));
                exp_idx_q.push_back(i % PE);
            end
            rem = job_bbox[f];
            while (rem > 0) begin
                exp_set_q.push_back((rem > PE) ? PE : rem);
                rem -= PE;
            end
        end
    endfunction

    // Runs a whole job as the core would, granting one credit per set.
    task automatic run_job(input int nfr, input int gmin, input int gmax);
        int k;
        int target;
        clear_mon();
        start = 1'b1; num_of_total_frames = FW'(nfr); start_cyc = cyc; tick(); start = 1'b0;
        for (int f = 0; f < nfr; f++) begin
            k = 0;
            while (!desc_ready && k < 100) begin tick(); k++; end
            if (!desc_ready) begin
                vectors++; miscompares++;
                $display("FAIL desc_wait: desc_ready=0 after %0d cycles, required 1", k);
                return;
            end
            desc_valid = 1'b1; desc_bbox_num = BW'(job_bbox[f]); desc_base_addr = AW'(job_base[f]);
            tick(); desc_valid = 1'b0;
            target = set_q.size();
            for (int r = job_bbox[f]; r > 0; r -= PE) begin
                repeat ($urandom_range(gmax, gmin)) tick();
                cr_cyc_q.push_back(cyc); ready_new_set = 1'b1; tick(); ready_new_set = 1'b0;
                target++;
                k = 0;
                while (set_q.size() < target && k < 200) begin tick(); k++; end
                if (set_q.size() < target) begin
                    vectors++; miscompares++;
                    $display("FAIL set_wait: %0d sets seen, required %0d", set_q.size(), target);
                    return;
                end
            end
            repeat ($urandom_range(gmax, gmin)) tick();
            rnf_cyc = cyc; ready_new_frame = 1'b1; tick(); ready_new_frame = 0;
        end
        k = 0;
        while (done_cnt == 0 && k < 50) begin tick(); k++; end
        if (done_cnt == 0) begin
            vectors++; miscompares++;
            $display("FAIL done_wait: done_all not seen, required a pulse");
        end
        repeat (4) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; repeat (3) tick();
        vectors++;
        if (out_vec !== '0) begin
            miscompares++; $display("FAIL reset_outputs: got %h, required 0", out_vec);
        end
        reset = 1'b0; tick();
        vectors++;
        if (out_vec !== '0) begin
            miscompares++; $display("FAIL idle_outputs: got %h, required 0", out_vec);
        end
    endtask

    task automatic test_two_set();
        int off;
        job_bbox[0] = 30; job_base[0] = 'h100;
        build_exp(1);
        run_job(1, 0, 0);
        vectors++;
        if (ln_kind_q.size() != 1 || ln_kind_q[0] != 0 || ln_frame_q[0] != 0 || ln_bbox_q[0] != 30) begin
            miscompares++; $display("FAIL two_set_launch: %0d launches, first kind/frame/bbox %0d/%0d/%0d, required 1 core_start 0/30",
                                    ln_kind_q.size(), ln_kind_q.size() ? ln_kind_q[0] : -1,
                                    ln_frame_q.size() ? ln_frame_q[0] : -1, ln_bbox_q.size() ? ln_bbox_q[0] : -1);
        end
        vectors++;
        if (ln_cyc_q.size() == 0 || ln_cyc_q[0] != start_cyc + 2) begin
            miscompares++; $display("FAIL two_set_launch_time: got cycle %0d, required %0d",
                                    ln_cyc_q.size() ? ln_cyc_q[0] : -1, start_cyc + 2);
        end
        vectors++;
        if (rd_q.size() != exp_rd_q.size()) begin
            miscompares++; $display("FAIL two_set_reads: %0d reads, required %0d", rd_q.size(), exp_rd_q.size());
        end
        foreach (exp_rd_q[i]) if (i < rd_q.size()) begin
            vectors++;
            if (rd_q[i] !== exp_rd_q[i]) begin
                miscompares++; $display("FAIL two_set_addr[%0d]: got %h, required %h", i, rd_q[i], exp_rd_q[i]);
            end
        end
        off = 0;
        foreach (exp_set_q[s]) begin
            vectors++;
            if (s >= set_q.size() || s >= cr_cyc_q.size() || off >= rd_cyc_q.size()) begin
                miscompares++; $display("FAIL two_set_set[%0d]: missing, required count %0d", s, exp_set_q[s]);
            end else if (set_q[s] != exp_set_q[s] || rd_cyc_q[off] != cr_cyc_q[s] + 2 ||
                         set_cyc_q[s] != rd_cyc_q[off] + exp_set_q[s] + 1) begin
                miscompares++; $display("FAIL two_set_set[%0d]: count %0d first_rd %0d announce %0d, required %0d %0d %0d",
                                        s, set_q[s], rd_cyc_q[off], set_cyc_q[s], exp_set_q[s],
                                        cr_cyc_q[s] + 2, cr_cyc_q[s] + exp_set_q[s] + 3);
            end
            off += exp_set_q[s];
        end
        vectors++;
        if (done_cnt != 1 || done_cyc != rnf_cyc + 2) begin
            miscompares++; $display("FAIL two_set_done: %0d pulses at %0d, required 1 at %0d", done_cnt, done_cyc, rnf_cyc + 2);
        end
    endtask

    task automatic test_multi_frame();
        for (int f = 0; f < 3; f++) begin job_bbox[f] = 24; job_base[f] = int'($urandom_range(4095, 0)); end
        build_exp(3);
        run_job(3, 0, 3);
        vectors++;
        if (ln_kind_q.size() != 3) begin
            miscompares++; $display("FAIL multi_launch_count: got %0d, required 3", ln_kind_q.size());
        end
        foreach (ln_kind_q[f]) begin
            vectors++;
            if (ln_kind_q[f] != ((f == 0) ? 0 : 1) || ln_frame_q[f] != f || ln_bbox_q[f] != 24) begin
                miscompares++; $display("FAIL multi_launch[%0d]: kind %0d frame %0d bbox %0d, required %0d %0d 24",
                                        f, ln_kind_q[f], ln_frame_q[f], ln_bbox_q[f], (f == 0) ? 0 : 1, f);
            end
        end
        vectors++;
        if (rd_q.size() != exp_rd_q.size()) begin
            miscompares++; $display("FAIL multi_reads: %0d reads, required %0d", rd_q.size(), exp_rd_q.size());
        end
        foreach (exp_rd_q[i]) if (i < rd_q.size()) begin
            vectors++;
            if (rd_q[i] !== exp_rd_q[i]) begin
                miscompares++; $display("FAIL multi_addr[%0d]: got %h, required %h", i, rd_q[i], exp_rd_q[i]);
            end
        end
        vectors++;
        if (done_cnt != 1) begin
            miscompares++; $display("FAIL multi_done: %0d pulses, required 1", done_cnt);
        end
    endtask

    task automatic test_credit();
        int k;
        // Saturation: four grants with nothing consuming.
        clear_mon();
        start = 1'b1; num_of_total_frames = FW'(1); tick(); start = 1'b0;
        for (int p = 0; p < 3; p++) begin ready_new_set = 1'b1; tick(); ready_new_set = 1'b0; tick(); end
        vectors++;
        if (credit_err !== 1'b0) begin
            miscompares++; $display("FAIL credit_three: credit_err=%b, required 0", credit_err);
        end
        ready_new_set = 1'b1; tick(); ready_new_set = 1'b0;
        vectors++;
        if (credit_err !== 1'b1) begin
            miscompares++; $display("FAIL credit_overflow: credit_err=%b, required 1", credit_err);
        end
        repeat (3) tick();
        vectors++;
        if (credit_err !== 1'b1) begin
            miscompares++; $display("FAIL credit_sticky: credit_err=%b, required 1", credit_err);
        end
        apply_reset();
        vectors++;
        if (credit_err !== 1'b0) begin
            miscompares++; $display("FAIL credit_reset: credit_err=%b, required 0", credit_err);
        end
        // Grant coinciding with a consumption: two grants must buy exactly two sets.
        clear_mon();
        start = 1'b1; num_of_total_frames = FW'(1); tick(); start = 1'b0;
        k = 0;
        while (!desc_ready && k < 20) begin tick(); k++; end
        desc_valid = 1'b1; desc_bbox_num = BW'(72); desc_base_addr = '0; tick(); desc_valid = 1'b0;
        ready_new_set = 1'b1; tick(); tick(); ready_new_set = 1'b0;
        repeat (200) tick();
        vectors++;
        if (set_q.size() != 2 || rd_q.size() != 48) begin
            miscompares++; $display("FAIL credit_same_cycle: %0d sets %0d reads, required 2 sets 48 reads", set_q.size(), rd_q.size());
        end
        apply_reset();
    endtask

    task automatic test_empty();
        job_bbox[0] = 0; job_base[0] = 'h3C0;
        run_job(1, 6, 6);
        vectors++;
        if (ln_kind_q.size() != 1 || ln_bbox_q[0] != 0 || rd_q.size() != 0 || set_q.size() != 0) begin
            miscompares++; $display("FAIL empty_frame: launches %0d reads %0d sets %0d, required 1 0 0",
                                    ln_kind_q.size(), rd_q.size(), set_q.size());
        end
        vectors++;
        if (done_cnt != 1 || done_cyc != rnf_cyc + 2) begin
            miscompares++; $display("FAIL empty_done: %0d pulses at %0d, required 1 at %0d", done_cnt, done_cyc, rnf_cyc + 2);
        end
    endtask

    task automatic test_reset_mid_fetch();
        int n = 0;
        int k = 0;
        int wr_after = 0;
        clear_mon();
        start = 1'b1; num_of_total_frames = FW'(1); tick(); start = 1'b0;
        desc_valid = 1'b1; desc_bbox_num = BW'(30); desc_base_addr = AW'('h200); tick(); desc_valid = 1'b0;
        ready_new_set = 1'b1; tick(); ready_new_set = 1'b0;
        while (k < 100) begin
            if (rd_en) n++;
            if (n == 10) break;
            tick(); k++;
        end
        vectors++;
        if (n != 10) begin
            miscompares++; $display("FAIL midfetch_reads: %0d reads seen, required 10", n);
        end
        reset = 1'b1; tick();
        vectors++;
        if (out_vec !== '0) begin
            miscompares++; $display("FAIL midfetch_reset: outputs %h, required 0", out_vec);
        end
        reset = 1'b0;
        repeat (5) begin tick(); if (fe_wr_en) wr_after++; end
        vectors++;
        if (wr_after != 0) begin
            miscompares++; $display("FAIL midfetch_writes: %0d writes after reset, required 0", wr_after);
        end
        job_bbox[0] = 5; job_base[0] = 'h040;
        build_exp(1);
        run_job(1, 0, 2);
        vectors++;
        if (rd_q.size() != 5 || set_q.size() != 1 || set_q[0] != 5 || rd_q[0] !== exp_rd_q[0] || done_cnt != 1) begin
            miscompares++; $display("FAIL midfetch_restart: reads %0d sets %0d done %0d, required 5 1 1",
                                    rd_q.size(), set_q.size(), done_cnt);
        end
    endtask

    task automatic test_addr_wrap();
        job_bbox[0] = 10; job_base[0] = 'hFFA;
        build_exp(1);
        run_job(1, 0, 1);
        vectors++;
        if (rd_q.size() != 10) begin
            miscompares++; $display("FAIL wrap_reads: %0d reads, required 10", rd_q.size());
        end
        foreach (exp_rd_q[i]) if (i < rd_q.size()) begin
            vectors++;
            if (rd_q[i] !== exp_rd_q[i]) begin
                miscompares++; $display("FAIL wrap_addr[%0d]: got %h, required %h", i, rd_q[i], exp_rd_q[i]);
            end
        end
    endtask

    task automatic test_random();
        int nfr;
        int off;
        for (int it = 0; it < 4; it++) begin
            nfr = int'($urandom_range(3, 1));
            for (int f = 0; f < nfr; f++) begin
                job_bbox[f] = int'($urandom_range(60, 0));
                job_base[f] = int'($urandom_range(4095, 0));
            end
            build_exp(nfr);
            run_job(nfr, 0, 4);
            vectors++;
            if (ln_kind_q.size() != nfr || rd_q.size() != exp_rd_q.size() || wr_q.size() != exp_idx_q.size() ||
                set_q.size() != exp_set_q.size() || done_cnt != 1) begin
                miscompares++; $display("FAIL rand%0d_counts: launch %0d rd %0d wr %0d set %0d done %0d, required %0d %0d %0d %0d 1",
                                        it, ln_kind_q.size(), rd_q.size(), wr_q.size(), set_q.size(), done_cnt,
                                        nfr, exp_rd_q.size(), exp_idx_q.size(), exp_set_q.size());
            end
            foreach (ln_kind_q[f]) if (f < nfr) begin
                vectors++;
                if (ln_kind_q[f] != ((f == 0) ? 0 : 1) || ln_frame_q[f] != f || ln_bbox_q[f] != job_bbox[f]) begin
                    miscompares++; $display("FAIL rand%0d_launch[%0d]: kind %0d frame %0d bbox %0d, required %0d %0d %0d",
                                            it, f, ln_kind_q[f], ln_frame_q[f], ln_bbox_q[f], (f == 0) ? 0 : 1, f, job_bbox[f]);
                end
            end
            foreach (exp_rd_q[i]) if (i < rd_q.size() && i < wr_q.size()) begin
                vectors++;
                if (rd_q[i] !== exp_rd_q[i] || wr_q[i] != exp_idx_q[i] || wr_cyc_q[i] != rd_cyc_q[i] + 1) begin
                    miscompares++; $display("FAIL rand%0d_beat[%0d]: addr %h idx %0d wr_lag %0d, required %h %0d 1",
                                            it, i, rd_q[i], wr_q[i], wr_cyc_q[i] - rd_cyc_q[i], exp_rd_q[i], exp_idx_q[i]);
                end
            end
            off = 0;
            foreach (exp_set_q[s]) begin
                if (s < set_q.size() && s < cr_cyc_q.size() && off < rd_cyc_q.size()) begin
                    vectors++;
                    if (set_q[s] != exp_set_q[s] || rd_cyc_q[off] != cr_cyc_q[s] + 2 ||
                        set_cyc_q[s] != rd_cyc_q[off] + exp_set_q[s] + 1) begin
                        miscompares++; $display("FAIL rand%0d_set[%0d]: count %0d first_rd %0d announce %0d, required %0d %0d %0d",
                                                it, s, set_q[s], rd_cyc_q[off], set_cyc_q[s], exp_set_q[s],
                                                cr_cyc_q[s] + 2, cr_cyc_q[s] + exp_set_q[s] + 3);
                    end
                end
                off += exp_set_q[s];
            end
        end
    endtask

    task automatic test_zero_frames();
        clear_mon();
        start = 1'b1; num_of_total_frames = '0; tick(); start = 1'b0;
        vectors++;
        if (done_all !== 1'b1 || desc_ready !== 1'b0) begin
            miscompares++; $display("FAIL zero_frames: done_all=%b desc_ready=%b, required 1 0", done_all, desc_ready);
        end
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_two_set();
        test_multi_frame();
        test_credit();
        test_empty();
        test_zero_frames();
        test_reset_mid_fetch();
        test_addr_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
